// File: rtl/write_txn_slave.sv
// ID-tagged write slave: byte-strobed register array with an in-order, latency-delayed response queue.
// Request acceptance and response return use independent valid/ready handshakes.

module write_txn_slave_chk (
  input logic clk,
  input logic rst_n,
  input logic valid,
  input logic rsp_ready
);

  a_no_x_handshake: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({valid, rsp_ready}));

endmodule

module write_txn_slave #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int DEPTH           = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_LATENCY     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 valid,
  output logic                                 ready,
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [DATA_WIDTH-1:0]                data,
  input  logic [DATA_WIDTH/8-1:0]              strb,
  input  logic [ID_WIDTH-1:0]                  id,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [ID_WIDTH-1:0]                  rsp_id,
  output logic [1:0]                           rsp,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [7:0]                           err_count,
  input  logic [ADDR_WIDTH-1:0]                dbg_addr,
  output logic [DATA_WIDTH-1:0]                dbg_data
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CDW = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CDW-1:0]        CD_INIT  = CDW'(RSP_LATENCY - 1);
  localparam logic [PW-1:0]         LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0]         MAX_C    = CW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem  [DEPTH];
  logic [ID_WIDTH-1:0]   r_q_id [MAX_OUTSTANDING];
  logic [1:0]            r_q_rsp[MAX_OUTSTANDING];
  logic [CDW-1:0]        r_q_cd [MAX_OUTSTANDING];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [7:0]            r_err;

  logic w_in_range;
  logic w_dbg_in_range;
  logic w_accept;
  logic w_pop;
  logic w_rsp_valid;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return '0;
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Handshake decode; ready and rsp_valid look only at registered queue state.
  always_comb begin
    w_in_range     = ({1'b0, addr} < DEPTH_C);
    w_dbg_in_range = ({1'b0, dbg_addr} < DEPTH_C);
    ready          = rst_n && (r_count < MAX_C);
    w_rsp_valid    = (r_count != '0) && (r_q_cd[r_rptr] == '0);
    w_accept       = valid && ready;
    w_pop          = w_rsp_valid && rsp_ready;
    if (w_rsp_valid) begin
      rsp_id = r_q_id[r_rptr];
      rsp    = r_q_rsp[r_rptr];
    end else begin
      rsp_id = '0;
      rsp    = 2'b00;
    end
    if (w_dbg_in_range) begin
      dbg_data = r_mem[dbg_addr[IW-1:0]];
    end else begin
      dbg_data = '0;
    end
  end

  assign rsp_valid   = w_rsp_valid;
  assign outstanding = r_count;
  assign err_count   = r_err;

  // Response queue, occupancy and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_q_id[i]  <= '0;
        r_q_rsp[i] <= 2'b00;
        r_q_cd[i]  <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 8'd0;
    end else begin
      // Every slot counts down, not just the head, so latency is measured from acceptance.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (r_q_cd[i] != '0) begin
          r_q_cd[i] <= r_q_cd[i] - CDW'(1);
        end
      end
      if (w_accept) begin
        r_q_id[r_wptr]  <= id;
        r_q_rsp[r_wptr] <= w_in_range ? 2'b00 : 2'b10;
        r_q_cd[r_wptr]  <= CD_INIT;
        r_wptr          <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_in_range && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  // Storage array with per-byte write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) begin
        r_mem[w] <= '0;
      end
    end else if (w_accept && w_in_range) begin
      for (int b = 0; b < SW; b++) begin
        if (strb[b]) begin
          r_mem[addr[IW-1:0]][b*8 +: 8] <= data[b*8 +: 8];
        end
      end
    end
  end

  write_txn_slave_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .rsp_ready (rsp_ready)
  );

endmodule

// File: tb/tb_write_txn_slave.sv
// Directed bench for write_txn_slave with default parameters (DEPTH=64, MAX_OUTSTANDING=4, RSP_LATENCY=2).
module tb_write_txn_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [3:0]  strb;
  logic [3:0]  id;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp;
  logic [2:0]  outstanding;
  logic [7:0]  err_count;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_pass   = 0;

  write_txn_slave dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .ready       (ready),
    .addr        (addr),
    .data        (data),
    .strb        (strb),
    .id          (id),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp         (rsp),
    .outstanding (outstanding),
    .err_count   (err_count),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic wr(input logic [3:0] i_id, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    check("wr_ready", 32'(ready), 32'd1);
    valid = 1'b1;
    id    = i_id;
    addr  = a;
    data  = d;
    strb  = s;
    step();
    valid = 1'b0;
  endtask

  // Single write with rsp_ready=1: one idle cycle, then the response, then drained.
  task automatic wr_rsp(input logic [3:0] i_id, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] exp_rsp);
    wr(i_id, a, d, s);
    check("lat_early", 32'(rsp_valid), 32'd0);
    check("lat_occ", 32'(outstanding), 32'd1);
    step();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(i_id));
    check("rsp_code", 32'(rsp), 32'(exp_rsp));
    step();
    check("drained", 32'(outstanding), 32'd0);
    check("drained_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    rst_n = 1'b0; valid = 1'b0; rsp_ready = 1'b0;
    addr = 8'd0; data = 32'd0; strb = 4'd0; id = 4'd0; dbg_addr = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp", 32'(rsp), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("ready_after_rst", 32'(ready), 32'd1);

    // Basic write
    wr_rsp(4'd3, 8'd5, 32'hDEADBEEF, 4'b1111, 2'b00);
    rd_check("mem5", 8'd5, 32'hDEADBEEF);

    // Byte strobes, then an all-zero strobe that must leave the word untouched
    wr_rsp(4'd1, 8'd7, 32'h11223344, 4'b1111, 2'b00);
    wr_rsp(4'd2, 8'd7, 32'hAABBCCDD, 4'b0101, 2'b00);
    rd_check("mem7_strb", 8'd7, 32'h11BB33DD);
    wr_rsp(4'd4, 8'd7, 32'hFFFFFFFF, 4'b0000, 2'b00);
    rd_check("mem7_nostrb", 8'd7, 32'h11BB33DD);

    // Out of range: SLVERR, no write (index 0 alias must stay clear)
    wr_rsp(4'd9, 8'd64, 32'h12345678, 4'b1111, 2'b10);
    check("err_one", 32'(err_count), 32'd1);
    rd_check("dbg_oor", 8'd64, 32'd0);
    rd_check("mem0_alias", 8'd0, 32'd0);

    // 299 more out-of-range writes saturate the counter at 255
    valid = 1'b1; id = 4'd9; addr = 8'd200; data = 32'hFFFFFFFF; strb = 4'hF;
    n_acc = 0;
    for (int k = 0; k < 299; k++) begin
      if (ready) n_acc++;
      step();
    end
    valid = 1'b0;
    repeat (4) step();
    check("burst_accepts", 32'(n_acc), 32'd299);
    check("err_sat", 32'(err_count), 32'd255);
    check("burst_drained", 32'(outstanding), 32'd0);

    // Backpressure / full queue / response stability
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(4'(i), 8'(10 + i), 32'(i), 4'b1111);
    end
    check("full_ready", 32'(ready), 32'd0);
    check("full_occ", 32'(outstanding), 32'd4);
    valid = 1'b1; id = 4'd4; addr = 8'd14; data = 32'd4; strb = 4'hF;
    for (int c = 0; c < 5; c++) begin
      step();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_id", 32'(rsp_id), 32'd0);
      check("hold_occ", 32'(outstanding), 32'd4);
    end
    rsp_ready = 1'b1;
    step();
    check("p1_ready", 32'(ready), 32'd1);
    check("p1_occ", 32'(outstanding), 32'd3);
    check("p1_id", 32'(rsp_id), 32'd1);
    step();
    check("p2_occ", 32'(outstanding), 32'd3);
    check("p2_id", 32'(rsp_id), 32'd2);
    id = 4'd5; addr = 8'd15; data = 32'd5;
    step();
    valid = 1'b0;
    check("p3_occ", 32'(outstanding), 32'd3);
    check("p3_id", 32'(rsp_id), 32'd3);
    step();
    check("p4_occ", 32'(outstanding), 32'd2);
    check("p4_id", 32'(rsp_id), 32'd4);
    step();
    check("p5_occ", 32'(outstanding), 32'd1);
    check("p5_id", 32'(rsp_id), 32'd5);
    step();
    check("p6_occ", 32'(outstanding), 32'd0);
    check("p6_valid", 32'(rsp_valid), 32'd0);
    rd_check("mem13", 8'd13, 32'd3);
    rd_check("mem15", 8'd15, 32'd5);

    // Asynchronous reset with responses pending
    rsp_ready = 1'b0;
    wr(4'd1, 8'd20, 32'hA0A0A0A0, 4'hF);
    wr(4'd2, 8'd21, 32'hB1B1B1B1, 4'hF);
    wr(4'd3, 8'd22, 32'hC2C2C2C2, 4'hF);
    step();
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    check("pre_rst_occ", 32'(outstanding), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_occ", 32'(outstanding), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    rd_check("mid_rst_mem20", 8'd20, 32'd0);
    rd_check("mid_rst_mem5", 8'd5, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    check("post_rst_occ", 32'(outstanding), 32'd0);
    check("post_rst_ready", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
